// File: rtl/result_demux_1x4_x64.sv
// One-to-four result demultiplexer with a single-word holding register per lane.
// Words whose select/invSelect pair disagrees are accepted and dropped, and counted as errors.
module result_demux_1x4_x64 #(
    parameter int WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [1:0]            select,
    input  logic [1:0]            invSelect,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [3:0][WIDTH-1:0] outs,
    output logic                  sel_err,
    output logic [7:0]            err_count
);

    logic [1:0] rst_sync;
    logic       active;
    logic       legal;
    logic       xfer;
    logic [3:0] load;

    // Reset release passes through two flops, so in_ready stays low until the second edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign active = rst_sync[1];
    assign legal  = (select == ~invSelect);

    // A draining lane counts as free, giving one word per cycle per lane.
    assign in_ready = active & (~legal | ~out_valid[select] | out_ready[select]);
    assign xfer     = in_valid & in_ready;
    assign load     = (xfer & legal) ? (4'b0001 << select) : 4'b0000;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 4'b0000;
            outs      <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (load[i]) begin
                    outs[i] <= in_data;
                end
                out_valid[i] <= load[i] | (out_valid[i] & ~out_ready[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err   <= 1'b0;
            err_count <= 8'd0;
        end else if (xfer && !legal) begin
            sel_err <= 1'b1;
            if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_result_demux_1x4_x64.sv
// Scoreboard bench for result_demux_1x4_x64: the driver pushes accepted words per lane,
// and a separate monitor pops and compares them as lanes drain.
module tb_result_demux_1x4_x64;

    localparam int W = 64;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic [1:0]        select;
    logic [1:0]        invSelect;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready;
    logic [3:0][W-1:0] outs;
    logic              sel_err;
    logic [7:0]        err_count;

    logic [W-1:0] exp_q [4][$];
    int           exp_err;
    bit           exp_sel_err;
    bit           mon_en;
    int           n_chk;
    int           n_fail;

    always #5 clk = ~clk;

    result_demux_1x4_x64 #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .select    (select),
        .invSelect (invSelect),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outs      (outs),
        .sel_err   (sel_err),
        .err_count (err_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: runs just after each falling edge, before the driver looks at in_ready.
    initial begin
        logic [3:0] ov_exp;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                for (int i = 0; i < 4; i++) ov_exp[i] = (exp_q[i].size() != 0);
                chk("out_valid", {60'd0, out_valid}, {60'd0, ov_exp});
                chk("err_count", {56'd0, err_count}, exp_err);
                chk("sel_err", {63'd0, sel_err}, {63'd0, exp_sel_err});
                for (int i = 0; i < 4; i++) begin
                    if (out_ready[i] && exp_q[i].size() != 0) begin
                        chk($sformatf("lane%0d data", i), outs[i], exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [1:0] s,
                         input logic [1:0] inv, input logic [3:0] ordy);
        logic lg;
        logic rdy_exp;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        select    = s;
        invSelect = inv;
        out_ready = ordy;
        #2;
        lg      = (s == ~inv);
        rdy_exp = !lg || (exp_q[s].size() == 0);
        chk("in_ready", {63'd0, in_ready}, {63'd0, rdy_exp});
        if (v && in_ready) begin
            if (lg) begin
                exp_q[s].push_back(d);
            end else begin
                exp_sel_err = 1'b1;
                if (exp_err < 255) exp_err++;
            end
        end
    endtask

    task automatic idle(input logic [3:0] ordy);
        drive(1'b0, '0, 2'd0, 2'd3, ordy);
    endtask

    initial begin
        logic [1:0]   s;
        logic [1:0]   inv;
        logic [W-1:0] d;
        n_chk       = 0;
        n_fail      = 0;
        exp_err     = 0;
        exp_sel_err = 1'b0;
        mon_en      = 1'b0;
        reset_n     = 1'b0;
        in_valid    = 1'b1;
        in_data     = '1;
        select      = 2'd0;
        invSelect   = 2'd3;
        out_ready   = 4'b0000;

        // Reset state
        #12;
        chk("reset out_valid", {60'd0, out_valid}, 64'd0);
        for (int i = 0; i < 4; i++) chk("reset outs", outs[i], 64'd0);
        chk("reset sel_err", {63'd0, sel_err}, 64'd0);
        chk("reset err_count", {56'd0, err_count}, 64'd0);
        chk("reset in_ready", {63'd0, in_ready}, 64'd0);

        // Release between edges; in_ready must wait for the synchronizer
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        chk("in_ready at release", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        chk("in_ready after 1st edge", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        mon_en = 1'b1;

        // Single route
        drive(1'b1, 64'hDEAD_BEEF_0000_0007, 2'd2, 2'd1, 4'b0000);
        idle(4'b0000);
        chk("route out_valid", {60'd0, out_valid}, 64'h4);
        chk("route outs2", outs[2], 64'hDEAD_BEEF_0000_0007);
        chk("route outs0", outs[0], 64'd0);
        idle(4'b0100);
        idle(4'b0000);

        // Backpressure on lane 1, lane 3 unaffected
        drive(1'b1, 64'hA1A1_0000_0000_0001, 2'd1, 2'd2, 4'b0000);
        drive(1'b1, 64'hB1B1_0000_0000_0002, 2'd1, 2'd2, 4'b0000);
        chk("bp in_ready lane1", {63'd0, in_ready}, 64'd0);
        chk("bp outs1 held", outs[1], 64'hA1A1_0000_0000_0001);
        drive(1'b1, 64'hC3C3_0000_0000_0003, 2'd3, 2'd0, 4'b0000);
        chk("bp in_ready lane3", {63'd0, in_ready}, 64'd1);
        idle(4'b0000);
        chk("bp out_valid", {60'd0, out_valid}, 64'hA);
        chk("bp outs1 still held", outs[1], 64'hA1A1_0000_0000_0001);
        idle(4'b1111);
        idle(4'b0000);

        // Streaming to lane 0 with no bubbles
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 64'h0000_0100 + 64'(k), 2'd0, 2'd3, 4'b0001);
            chk("stream in_ready", {63'd0, in_ready}, 64'd1);
        end
        idle(4'b0001);
        idle(4'b0000);

        // Illegal selects: counter saturates at 255
        for (int k = 0; k < 300; k++) drive(1'b1, 64'(k), 2'b01, 2'b01, 4'b0000);
        idle(4'b0000);
        chk("illegal err_count", {56'd0, err_count}, 64'd255);
        chk("illegal sel_err", {63'd0, sel_err}, 64'd1);
        chk("illegal out_valid", {60'd0, out_valid}, 64'd0);

        // Async reset with all lanes full
        for (int k = 0; k < 4; k++) drive(1'b1, 64'hF000 + 64'(k), 2'(k), ~2'(k), 4'b0000);
        idle(4'b0000);
        chk("pre-reset out_valid", {60'd0, out_valid}, 64'hF);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        exp_err     = 0;
        exp_sel_err = 1'b0;
        #1;
        chk("async out_valid", {60'd0, out_valid}, 64'd0);
        chk("async err_count", {56'd0, err_count}, 64'd0);
        chk("async outs3", outs[3], 64'd0);
        @(negedge clk);
        #3;
        reset_n = 1'b1;
        #1;
        chk("async in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        @(posedge clk);

        // Mixed random traffic against the scoreboard
        for (int k = 0; k < 10000; k++) begin
            s   = 2'($urandom_range(0, 3));
            inv = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : ~s;
            d   = {$urandom, $urandom};
            drive(($urandom_range(0, 3) != 0), d, s, inv, 4'($urandom_range(0, 15)));
        end
        repeat (4) idle(4'b1111);
        for (int i = 0; i < 4; i++) chk("lane drained", 64'(exp_q[i].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/result_demux_1x4_x64.md
RESULT_DEMUX_1X4_X64 -- requirements
Module: result_demux_1x4_X64

Interface
REQ-001 Parameter: WIDTH, 64, data width of input and each output lane.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_valid  input  1  producer has a word this cycle.
REQ-005 Port: in_ready  output  1  block accepts the word this cycle.
REQ-006 Port: in_data  input  WIDTH  word to route.
REQ-007 Port: select  input  2  destination lane index.
REQ-008 Port: invSelect  input  2  bitwise complement of select, supplied by the producer.
REQ-009 Port: out_valid  output  4  per-lane holding register full.
REQ-010 Port: out_ready  input  4  per-lane consumer accepts.
REQ-011 Port: outs  output  4xWIDTH  packed per-lane data, outs[i] belongs to lane i.
REQ-012 Port: sel_err  output  1  sticky flag, set when select != ~invSelect on an accepted transfer.
REQ-013 Port: err_count  output  8  saturating count of dropped transfers.

Function
REQ-014 Each lane i SHALL own exactly one WIDTH-bit holding register plus a valid bit.
REQ-015 Transfer: in_valid & in_ready at a rising edge.
REQ-016 Lane i SHALL be free when out_valid[i]=0, or when out_valid[i]=1 and out_ready[i]=1.
REQ-017 in_ready SHALL be combinational and asserted in either case:
- select==~invSelect and lane[select] is free;
- select!=~invSelect, so the word is dropped.
REQ-018 A legal transfer SHALL load outs[select]<=in_data and set out_valid[select] on the same edge.
- Latency is 1 cycle from transfer to out_valid.
REQ-019 A lane drain SHALL occur when out_valid[i] & out_ready[i], and SHALL clear out_valid[i] unless the lane is reloaded on the same edge.
REQ-020 Simultaneous drain and load on the same lane SHALL leave out_valid[i]=1 with the new data, giving full throughput of one word per cycle per lane.
REQ-021 Only the selected lane SHALL change on a load; all other lanes hold data and valid, apart from their own drains.
REQ-022 outs[i] SHALL remain stable while out_valid[i]=1 and out_ready[i]=0.
REQ-023 An illegal transfer (select!=~invSelect) SHALL:
- write no lane;
- set sel_err;
- increment err_count, which saturates at 255 and never wraps.
REQ-024 sel_err SHALL stay set until reset.
REQ-025 Drains on other lanes SHALL proceed normally during an illegal transfer.
REQ-026 Any lane may drain on any cycle, independent of input activity. All four lanes may drain on the same edge.
REQ-027 A lane that is full and not draining SHALL deassert in_ready for a legal word targeting it. No other lane's traffic is affected.

Reset
REQ-028 While reset_n=0, the block SHALL hold:
- out_valid=4'b0000;
- outs all zero;
- sel_err=0;
- err_count=0.
REQ-029 While reset_n=0, in_ready SHALL be 0.
REQ-030 Assertion of reset_n SHALL take effect immediately, without a clock edge, even mid-transfer. Any held data is discarded.
REQ-031 Deassertion SHALL be synchronized internally. in_ready SHALL not assert before the first rising edge after reset_n rises.

Verification
REQ-032 Single route: select=2, invSelect=1, in_data=64'hDEAD_BEEF_0000_0007, all out_ready=0 -> next cycle out_valid=4'b0100, outs[2]=64'hDEAD_BEEF_0000_0007, other lanes unchanged.
REQ-033 Backpressure: lane 1 full with out_ready[1]=0, new word to lane 1 -> in_ready=0 and outs[1] held. The same cycle, a word to lane 3 is accepted.
REQ-034 Streaming: 16 back-to-back words to lane 0 with out_ready[0]=1 -> in_ready=1 every cycle, lane 0 emits all 16 in order, no bubbles.
REQ-035 Illegal select: select=2'b01, invSelect=2'b01, 300 transfers -> all accepted, no out_valid change, sel_err=1, err_count=255.
REQ-036 Async reset: reset_n pulled low between clock edges with out_valid=4'b1111 -> out_valid=0 and err_count=0 before the next edge.
REQ-037 Mixed traffic: random select, invSelect and out_ready against a scoreboard over 10k cycles -> no loss, duplication or reorder per lane, and outs bits 0-63 match in_data bit-for-bit on every lane.
